// File: rtl/plab5_mcore_mem_req_net_adapter_if.sv
// Handshake bundle between a memory request port and the request network:
// the request side (val/rdy + mode/domain) and the split control/data network side.
interface plab5_mcore_mem_req_net_adapter_if #(
    parameter int unsigned p_mem_opaque_nbits  = 8,
    parameter int unsigned p_mem_addr_nbits    = 32,
    parameter int unsigned p_mem_data_nbits    = 32,
    parameter int unsigned p_net_opaque_nbits  = 4,
    parameter int unsigned p_net_srcdest_nbits = 3
);
    localparam int unsigned LEN_NBITS  = $clog2(p_mem_data_nbits / 8);
    localparam int unsigned REQ_NBITS  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                                         + LEN_NBITS + p_mem_data_nbits;
    localparam int unsigned CTRL_NBITS = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LEN_NBITS
                                         + p_net_opaque_nbits + 2 * p_net_srcdest_nbits + 1;

    logic                        in_val;
    logic                        in_rdy;
    logic                        in_mode;
    logic                        in_domain;
    logic [REQ_NBITS-1:0]        in_msg;

    logic                        out_val;
    logic                        out_rdy;
    logic                        out_domain;
    logic [CTRL_NBITS-1:0]       out_msg_control;
    logic [p_mem_data_nbits-1:0] out_msg_data;

    // Requester / network-consumer side
    modport master (
        output in_val, in_mode, in_domain, in_msg, out_rdy,
        input  in_rdy, out_val, out_domain, out_msg_control, out_msg_data
    );

    // Adapter side
    modport slave (
        input  in_val, in_mode, in_domain, in_msg, out_rdy,
        output in_rdy, out_val, out_domain, out_msg_control, out_msg_data
    );
endinterface

// File: rtl/plab5_mcore_mem_req_net_adapter.sv
// Buffered memory-request to network-message adapter: queues requests with mode/domain,
// maps the head address to a destination bank and stamps the source id into the opaque.
module plab5_mcore_mem_req_net_adapter #(
    parameter int unsigned p_net_src           = 0,
    parameter int unsigned p_num_banks         = 2,
    parameter int unsigned p_map_mode          = 1,
    parameter int unsigned p_inst_split_addr   = 32'h4000,
    parameter int unsigned p_data_split_addr   = 32'hc000,
    parameter int unsigned p_cacheline_nwords  = 4,
    parameter int unsigned p_num_entries       = 4,
    parameter int unsigned p_domain_drain      = 1,
    parameter int unsigned p_mem_opaque_nbits  = 8,
    parameter int unsigned p_mem_addr_nbits    = 32,
    parameter int unsigned p_mem_data_nbits    = 32,
    parameter int unsigned p_net_opaque_nbits  = 4,
    parameter int unsigned p_net_srcdest_nbits = 3
) (
    input logic clk,
    input logic reset,
    plab5_mcore_mem_req_net_adapter_if.slave bus
);
    localparam int unsigned MO       = p_mem_opaque_nbits;
    localparam int unsigned MA       = p_mem_addr_nbits;
    localparam int unsigned MD       = p_mem_data_nbits;
    localparam int unsigned NO       = p_net_opaque_nbits;
    localparam int unsigned NS       = p_net_srcdest_nbits;
    localparam int unsigned LEN_NB   = $clog2(MD / 8);
    localparam int unsigned REQ_NB   = 3 + MO + MA + LEN_NB + MD;
    localparam int unsigned PTR_NB   = $clog2(p_num_entries);
    localparam int unsigned CNT_NB   = PTR_NB + 1;
    localparam int unsigned BANK_NB  = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;
    localparam int unsigned ILV_LSB  = 2 + $clog2(p_cacheline_nwords);
    localparam int unsigned LEN_LSB  = MD;
    localparam int unsigned ADDR_LSB = LEN_LSB + LEN_NB;
    localparam int unsigned OPQ_LSB  = ADDR_LSB + MA;
    localparam int unsigned TYPE_LSB = OPQ_LSB + MO;

    localparam logic [NS-1:0]     SRC_ID     = NS'(p_net_src);
    localparam logic              REQ_DOMAIN = 1'(p_net_src % 2);
    localparam logic [CNT_NB-1:0] FULL_CNT   = CNT_NB'(p_num_entries);

    // Queue storage; payload is intentionally left unreset
    logic [REQ_NB-1:0] msg_mem    [p_num_entries];
    logic              mode_mem   [p_num_entries];
    logic              domain_mem [p_num_entries];

    logic [PTR_NB-1:0] head;
    logic [PTR_NB-1:0] tail;
    logic [CNT_NB-1:0] count;
    logic              q_domain;

    logic              in_rdy_w;
    logic              out_val_w;
    logic              enq;
    logic              deq;
    logic              domain_block;

    logic [REQ_NB-1:0] head_msg;
    logic              head_mode;
    logic [2:0]        head_type;
    logic [MO-1:0]     head_opaque;
    logic [MA-1:0]     head_addr;
    logic [LEN_NB-1:0] head_len;
    logic [MD-1:0]     head_data;
    logic [MA-1:0]     split_addr;
    logic [BANK_NB-1:0] bank_sel;
    logic [NS-1:0]     dest;
    logic [MO-1:0]     opaque_out;
    logic              unused_opaque_hi;

    // A request from another domain waits until the queue has fully drained
    assign domain_block = (p_domain_drain != 0) && (count != '0) && (bus.in_domain != q_domain);
    assign in_rdy_w     = (count != FULL_CNT) && !domain_block;
    assign out_val_w    = (count != '0);
    assign enq          = bus.in_val && in_rdy_w;
    assign deq          = out_val_w && bus.out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            q_domain <= 1'b0;
        end else begin
            if (enq) begin
                tail     <= tail + PTR_NB'(1);
                q_domain <= bus.in_domain;
            end
            if (deq) begin
                head <= head + PTR_NB'(1);
            end
            if (enq && !deq) begin
                count <= count + CNT_NB'(1);
            end else if (!enq && deq) begin
                count <= count - CNT_NB'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            msg_mem[tail]    <= bus.in_msg;
            mode_mem[tail]   <= bus.in_mode;
            domain_mem[tail] <= bus.in_domain;
        end
    end

    assign head_msg    = msg_mem[head];
    assign head_mode   = mode_mem[head];
    assign head_type   = head_msg[TYPE_LSB +: 3];
    assign head_opaque = head_msg[OPQ_LSB +: MO];
    assign head_addr   = head_msg[ADDR_LSB +: MA];
    assign head_len    = head_msg[LEN_LSB +: LEN_NB];
    assign head_data   = head_msg[MD-1:0];

    assign split_addr = head_mode ? MA'(p_data_split_addr) : MA'(p_inst_split_addr);
    assign bank_sel   = head_addr[ILV_LSB +: BANK_NB];

    // Destination bank under the selected address map
    always_comb begin
        dest = '0;
        if (p_map_mode == 1) begin
            if (head_addr >= split_addr) begin
                dest = NS'(1);
            end
        end else if (p_map_mode == 2 && p_num_banks > 1) begin
            dest = NS'(bank_sel);
        end
    end

    // Source id replaces the opaque MSBs so responses can be routed back
    assign opaque_out       = {SRC_ID, head_opaque[MO-NS-1:0]};
    assign unused_opaque_hi = ^head_opaque[MO-1 -: NS];

    assign bus.in_rdy          = in_rdy_w;
    assign bus.out_val         = out_val_w;
    assign bus.out_domain      = domain_mem[head];
    assign bus.out_msg_control = {dest, SRC_ID, {NO{1'b0}}, REQ_DOMAIN,
                                  head_type, opaque_out, head_addr, head_len};
    assign bus.out_msg_data    = head_data;
endmodule

// File: doc/plab5_mcore_mem_req_net_adapter.md
# plab5_mcore_mem_req_net_adapter

Buffered, parametrised memory-request-to-network adapter between a core's (or cache's) memory request port and the request network. Accepts memory requests over val/rdy, stores each with its mode and security domain in a FIFO, computes the destination bank under a selectable address map, and rewrites the opaque field with the source id. Emits the split control/data network message over val/rdy. An optional domain-drain rule keeps requests of different domains from sharing the queue.

## Interface
- p_net_src, 0, source id (core id); low `ns` bits go into the src field and opaque MSBs
- p_num_banks, 2, destination banks (power of 2, ≤ 2^ns)
- p_map_mode, 1, 0 = single bank, 1 = range split, 2 = cacheline interleave
- p_inst_split_addr, 32'h4000, range-split boundary when mode = 0 (inst)
- p_data_split_addr, 32'hc000, range-split boundary when mode = 1 (data)
- p_cacheline_nwords, 4, words per line; interleave LSB = 2 + clog2(p_cacheline_nwords)
- p_num_entries, 4, FIFO depth (power of 2, ≥ 2)
- p_domain_drain, 1, 1 = refuse a request whose domain differs from queued entries
- p_mem_opaque_nbits (mo) 8, p_mem_addr_nbits (ma) 32, p_mem_data_nbits (md) 32, p_net_opaque_nbits (no) 4, p_net_srcdest_nbits (ns) 3
- clk, in, 1, clock
- reset, in, 1, asynchronous, active-low reset
- in_val / in_rdy, in/out, 1/1, request handshake
- in_mode, in, 1, 0 = inst, 1 = data; sampled with the request
- in_domain, in, 1, security domain of the request; sampled with the request
- in_msg, in, VC_MEM_REQ_MSG_NBITS(mo,ma,md), memory request {type, opaque, addr, len, data}
- out_val / out_rdy, out/in, 1/1, network handshake
- out_domain, out, 1, domain of the head entry
- out_msg_control, out, VC_NET_MSG_NBITS(npc,no,ns)+1, {dest, src, opaque = 0, req_domain, type, opaque', addr, len}
- out_msg_data, out, md, data field of the head entry

## Operation
- Enqueue on in_val && in_rdy. Store the raw in_msg, in_mode, and in_domain in the tail entry. Tail pointer += 1 mod p_num_entries; count += 1.
- Dequeue on out_val && out_rdy. Head pointer += 1 mod p_num_entries; count -= 1.
- in_rdy = (count != p_num_entries) && !(p_domain_drain && count != 0 && in_domain != q_domain).
  - q_domain is a register holding the domain of queued entries; it is written on every enqueue.
  - in_rdy depends on in_domain; out_val does not depend on in_val.
- out_val = (count != 0). Output fields are derived combinationally from the head entry.
- dest (zero-extended to ns bits):
  - map 0: 0
  - map 1: addr < (mode ? p_data_split_addr : p_inst_split_addr) ? 0 : 1
  - map 2: addr[lsb +: clog2(p_num_banks)]
- opaque' = {p_net_src[ns-1:0], opaque[mo-ns-1:0]}.
- req_domain = p_net_src[0] (odd source = 1).
- out_msg_data = the stored data field, passed unmodified for all types.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- When full: in_rdy = 0 even if out_rdy = 1 (no full pass-through).
- When empty: no bypass; out_val = 0 regardless of in_val.

## Timing
- Latency: request accepted at edge N; out_val high from cycle N+1 at the earliest.
- Throughput: one request per cycle when neither full nor domain-blocked.
- Reset (reset = 0, async) forces: head = tail = 0, count = 0, q_domain = 0, out_val = 0, in_rdy = 1. Payload storage is not reset.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge. The first acceptance after release occurs at the first rising edge with reset = 1.
- After a domain switch, a blocked request is accepted in the same cycle the last old-domain entry is dequeued only if it arrives on a later cycle. The block holds because count != 0 still holds in the dequeue cycle.
- out_msg_control, out_msg_data, and out_domain are stable while out_val && !out_rdy.

## Test plan
- Single read, map 1, mode 1, addr 32'hc004, p_net_src = 3, opaque 8'h05 -> one cycle later out_val = 1, dest = 1, src = 3, opaque' = 8'h65, req_domain = 1.
- Map 1, mode 0, addr 32'h3ffc -> dest = 0; addr 32'h4000 -> dest = 1. Map 2, p_num_banks = 4, addr 32'h0000_0030 -> dest = 3.
- out_rdy held 0, depth 4: 4 requests accepted, then in_rdy = 0. out_rdy = 1 for one cycle drains the head in order (1st request). in_rdy = 1 in the next cycle.
- Streaming with in_val = out_rdy = 1 continuously, 16 requests -> 16 outputs in order, one per cycle after 1-cycle latency; count never exceeds 1.
- p_domain_drain = 1: two domain-0 requests queued, then a domain-1 request -> in_rdy = 0 until count = 0. It is then accepted, and out_domain = 1 for that entry.
- Reset pulsed low mid-stream with 3 entries queued -> out_val = 0 and in_rdy = 1 immediately, without a clock edge. After release, no stale entry is emitted.
